// File: rtl/b20_decode_if.sv
// Candidate-in / decoded-result-out bus of the b20 decode stage.
// The master side feeds candidates and accepts results; the slave side is the decoder.
interface b20_decode_if #(
  parameter int unsigned CNT_W = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [19:0]      KEY20;
  logic             EXP_BIT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [14:0]      CTR;
  logic             BIT_OUT;
  logic [3:0]       IDX_OUT;
  logic             MATCH;
  logic             CLR;
  logic [CNT_W-1:0] MATCH_CNT;

  modport master (
    output IN_VALID, KEY20, EXP_BIT, OUT_READY, CLR,
    input  IN_READY, OUT_VALID, CTR, BIT_OUT, IDX_OUT, MATCH, MATCH_CNT
  );

  modport slave (
    input  IN_VALID, KEY20, EXP_BIT, OUT_READY, CLR,
    output IN_READY, OUT_VALID, CTR, BIT_OUT, IDX_OUT, MATCH, MATCH_CNT
  );
endinterface

// File: rtl/b20_decode.sv
// Inverse of the 20-bit key-fragment enumerator: recovers counter, Fc bit and Fc index of a
// candidate in a two-stage valid/ready pipeline, and counts results matching the expected index.
module b20_decode #(
  parameter logic [3:0]  IDX   = 4'd0,
  parameter int unsigned CNT_W = 16
) (
  input logic          CLK,
  input logic          RESETn,
  b20_decode_if.slave  bus
);

  localparam logic [15:0] FA = 16'h9E98;
  localparam logic [15:0] FB = 16'hB48E;
  localparam logic [31:0] FC = 32'hEC57E80A;

  // Position of v among the inputs of tbl that produce the same output bit.
  function automatic logic [2:0] rank16(input logic [15:0] tbl, input logic [3:0] v);
    logic [2:0] r;
    r = '0;
    for (int u = 0; u < 16; u++) begin
      if ((u[3:0] < v) && (tbl[u[3:0]] == tbl[v])) r = r + 3'd1;
    end
    return r;
  endfunction

  function automatic logic [3:0] rank32(input logic [31:0] tbl, input logic [4:0] v);
    logic [3:0] r;
    r = '0;
    for (int u = 0; u < 32; u++) begin
      if ((u[4:0] < v) && (tbl[u[4:0]] == tbl[v])) r = r + 4'd1;
    end
    return r;
  endfunction

  logic             s1_valid_q;
  logic [4:0]       s1_sel_q,  s1_sel_d;
  logic [14:0]      s1_rank_q, s1_rank_d;
  logic             s1_exp_q;

  logic             out_valid_q;
  logic [14:0]      ctr_q;
  logic             bit_q,   bit_d;
  logic [3:0]       idx_q,   idx_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic s2_accept, in_ready, in_fire, out_fire;

  assign s2_accept = !out_valid_q || bus.OUT_READY;
  assign in_ready  = !s1_valid_q || s2_accept;
  assign in_fire   = bus.IN_VALID && in_ready;
  assign out_fire  = out_valid_q && bus.OUT_READY;

  always_comb begin
    s1_sel_d  = {FB[bus.KEY20[3:0]], FA[bus.KEY20[7:4]], FA[bus.KEY20[11:8]],
                 FB[bus.KEY20[15:12]], FA[bus.KEY20[19:16]]};
    s1_rank_d = {rank16(FA, bus.KEY20[19:16]), rank16(FB, bus.KEY20[15:12]),
                 rank16(FA, bus.KEY20[11:8]),  rank16(FA, bus.KEY20[7:4]),
                 rank16(FB, bus.KEY20[3:0])};
  end

  always_comb begin
    bit_d   = FC[s1_sel_q];
    idx_d   = rank32(FC, s1_sel_q);
    match_d = (idx_d == IDX) && (bit_d == s1_exp_q);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.CLR) begin
      cnt_d = '0;
    end else if (out_fire && match_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= '0;
      s1_rank_q  <= '0;
      s1_exp_q   <= 1'b0;
    end else if (in_ready) begin
      // S1 empties here unless a new candidate arrives in the same cycle.
      s1_valid_q <= bus.IN_VALID;
      if (in_fire) begin
        s1_sel_q  <= s1_sel_d;
        s1_rank_q <= s1_rank_d;
        s1_exp_q  <= bus.EXP_BIT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_valid_q <= 1'b0;
      ctr_q       <= '0;
      bit_q       <= 1'b0;
      idx_q       <= '0;
      match_q     <= 1'b0;
    end else if (s2_accept) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        ctr_q   <= s1_rank_q;
        bit_q   <= bit_d;
        idx_q   <= idx_d;
        match_q <= match_d;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.CTR       = ctr_q;
  assign bus.BIT_OUT   = bit_q;
  assign bus.IDX_OUT   = idx_q;
  assign bus.MATCH     = match_q;
  assign bus.MATCH_CNT = cnt_q;

endmodule
